// File: rtl/sonic_vc_tx_port_arbiter.sv
// Packet-granular round-robin arbiter merging N ready/valid ports onto one registered stream.
// A grant is held from the first beat to the in_eop beat; each output beat carries its source channel.
module sonic_vc_tx_port_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 133,
    parameter int CH_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PORTS-1:0]            port_en,
    input  logic [N_PORTS-1:0]            in_valid,
    input  logic [N_PORTS-1:0]            in_eop,
    input  logic [N_PORTS*DATA_WIDTH-1:0] in_data,
    output logic [N_PORTS-1:0]            in_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_eop,
    output logic [CH_WIDTH-1:0]           out_channel,
    input  logic                          out_ready,
    output logic                          busy
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t                state, state_next;
    logic [CH_WIDTH-1:0]   grant, grant_next, last_grant;
    logic [CH_WIDTH-1:0]   pick;
    logic                  found;
    logic [N_PORTS-1:0]    eligible;
    logic                  accept;
    logic                  sel_valid, sel_eop;
    logic [DATA_WIDTH-1:0] sel_data;

    assign eligible = in_valid & port_en;

    // Walk from farthest to nearest so the port closest after last_grant wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = N_PORTS; k >= 1; k--) begin
            if (eligible[(int'(last_grant) + k) % N_PORTS]) begin
                pick  = CH_WIDTH'((int'(last_grant) + k) % N_PORTS);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant == CH_WIDTH'(i)) begin
                sel_valid = in_valid[i];
                sel_eop   = in_eop[i];
                sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept = (state == PKT) && sel_valid && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_WIDTH'(N_PORTS - 1);
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (accept && sel_eop)
                last_grant <= grant;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        case (state)
            IDLE: if (found) begin
                state_next = PKT;
                grant_next = pick;
            end
            PKT: if (accept && sel_eop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = '0;
        busy     = (state == PKT);
        if (state == PKT) begin
            for (int i = 0; i < N_PORTS; i++)
                if (grant == CH_WIDTH'(i)) in_ready[i] = !out_valid || out_ready;
        end
    end

    // A new accept and a drain in the same cycle keeps out_valid high with the new beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_eop     <= 1'b0;
            out_channel <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_data    <= sel_data;
            out_eop     <= sel_eop;
            out_channel <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sonic_vc_tx_port_arbiter.sv
// Randomized bench: per-port packet sources, random backpressure and enables, checked every
// cycle against a transaction-level reference of the round-robin packet arbiter.
module tb_sonic_vc_tx_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 133;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      port_en, in_valid, in_eop, in_ready;
    logic [N*DW-1:0]   in_data;
    logic              out_valid, out_eop, out_ready, busy;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_channel;

    sonic_vc_tx_port_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW), .CH_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .port_en(port_en), .in_valid(in_valid), .in_eop(in_eop),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_eop(out_eop), .out_channel(out_channel), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Packet sources: current beat per port and beats left in the packet.
    logic [DW-1:0] beat_data [N];
    int            rem [N];

    // Reference: busy flag, granted port, round-robin pointer, output register contents.
    int            m_busy, m_g, m_last, m_ov, m_oe, m_oc;
    logic [DW-1:0] m_od;

    // Stimulus knobs.
    logic [N-1:0]  vmask;
    int            vpct, rpct, rst_pct, en_flip_pct;
    logic          rst_force;

    function automatic logic [DW-1:0] rnd_beat();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_last = N - 1;
        m_ov = 0; m_oe = 0; m_oc = 0; m_od = '0;
    endtask

    // Drive at the falling edge, check the current state, then advance the reference
    // across the coming rising edge.
    task automatic cycle();
        logic [N-1:0] exp_ir, acc;
        logic         rst_now;
        int           p;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = vmask[i] && ($urandom_range(99) < vpct);
            in_eop[i]   = (rem[i] == 1);
            in_data[i*DW +: DW] = beat_data[i];
        end
        out_ready = ($urandom_range(99) < rpct);
        if ($urandom_range(99) < en_flip_pct) port_en = N'($urandom);
        rst_now = rst_force || ($urandom_range(999) < rst_pct);
        reset   = rst_now;
        #1;
        exp_ir = '0;
        if (m_busy != 0) exp_ir[m_g] = (m_ov == 0) || out_ready;
        chk("in_ready", DW'(in_ready), DW'(exp_ir));
        chk("busy", DW'(busy), DW'(m_busy));
        chk("out_valid", DW'(out_valid), DW'(m_ov));
        chk("out_data", out_data, m_od);
        chk("out_eop", DW'(out_eop), DW'(m_oe));
        chk("out_channel", DW'(out_channel), DW'(m_oc));
        acc = in_valid & in_ready;

        if (rst_now) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (m_ov != 0 && out_ready) m_ov = 0;
            for (int k = 1; k <= N; k++) begin
                p = (m_last + k) % N;
                if (in_valid[p] && port_en[p]) begin
                    m_g = p; m_busy = 1;
                    break;
                end
            end
        end else if (in_valid[m_g] && exp_ir[m_g]) begin
            m_od = beat_data[m_g]; m_oe = in_eop[m_g]; m_oc = m_g; m_ov = 1;
            if (in_eop[m_g]) begin
                m_last = m_g; m_busy = 0;
            end
        end else if (m_ov != 0 && out_ready) begin
            m_ov = 0;
        end

        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                beat_data[i] = rnd_beat();
                rem[i] = (rem[i] == 1) ? $urandom_range(4, 1) : rem[i] - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    initial begin
        int waited;
        reset = 1'b1; port_en = '1; in_valid = '0; in_eop = '0; in_data = '0; out_ready = 1'b0;
        rst_force = 1'b0; rst_pct = 0; en_flip_pct = 0;
        for (int i = 0; i < N; i++) begin
            beat_data[i] = rnd_beat();
            rem[i] = $urandom_range(4, 1);
        end
        rem[0] = 3;
        model_reset();
        @(negedge clk);

        // Reset, then a lone 3-beat packet on port 0 with a free output.
        rst_force = 1'b1; vmask = '0; vpct = 0; rpct = 100;
        run(2);
        rst_force = 1'b0; vmask = 4'b0001; vpct = 100;
        run(8);

        // All ports busy: round-robin with a bubble between packets.
        vmask = '1;
        run(40);
        // Backpressure and source gaps.
        rpct = 30; vpct = 80;
        run(200);
        // Only odd ports enabled.
        port_en = 4'b1010; rpct = 70; vpct = 100;
        run(100);
        // Enables flipping mid-packet, sporadic resets.
        vpct = 70; rpct = 60; en_flip_pct = 5; rst_pct = 10;
        run(2000);

        // Reset while a beat sits in the output register mid-packet.
        en_flip_pct = 0; rst_pct = 0; port_en = '1; vmask = '1; vpct = 100; rpct = 0;
        waited = 0;
        while (!(m_busy != 0 && m_ov != 0) && waited < 60) begin
            rpct = (waited % 3 == 0) ? 100 : 0;
            cycle();
            waited++;
        end
        chk("reset_setup_reached", DW'(m_busy != 0 && m_ov != 0), DW'(1));
        rst_force = 1'b1; rpct = 0;
        run(1);
        rst_force = 1'b0; rpct = 100;
        #1;
        chk("post_rst_out_valid", DW'(out_valid), DW'(0));
        chk("post_rst_busy", DW'(busy), DW'(0));
        run(2);
        #1;
        chk("post_rst_first_valid", DW'(out_valid), DW'(1));
        chk("post_rst_first_channel", DW'(out_channel), DW'(0));
        run(20);

        // Nothing enabled: arbiter stays idle.
        port_en = '0;
        run(30);
        #1;
        chk("all_disabled_idle", DW'({busy, in_ready}), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
